// File: rtl/bubble_pkg.sv
// bubble_pkg: shared state encoding and default index width for the bubble-sort index generator
package bubble_pkg;
    localparam int IDX_W = 16;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMP      = 2'd1,
        PASS_END = 2'd2,
        DONE     = 2'd3
    } state_e;
endpackage

// File: rtl/bubble_j_counter.sv
// bubble_j_counter: clearable compare-index counter with end-of-pass detect
// Ports: clr_i clears j, en_i increments j, last_o flags j == lim_i-1-i_i.
module bubble_j_counter import bubble_pkg::*; #(
    parameter int N = IDX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [N-1:0] lim_i,
    input  logic [N-1:0] i_i,
    output logic [N-1:0] j_o,
    output logic         last_o
);
    logic [N-1:0] j_q, j_d;
    always_comb j_d = clr_i ? '0 : en_i ? j_q + 1'b1 : j_q;
    always_ff @(posedge clk) begin
        if (!rst) j_q <= '0;
        else      j_q <= j_d;
    end
    assign j_o    = j_q;
    // i never exceeds lim-1, so this difference cannot wrap
    assign last_o = j_q == lim_i - 1'b1 - i_i;
endmodule

// File: rtl/bubble_index_gen.sv
// bubble_index_gen: sequences pass index i and compare index j for a top-down bubble sort
// Ports: start/n_1 launch a sort; step/swapped_in close each compare;
// cmp_valid/idx_j/idx_i request a compare; busy, pass_done and done report progress.
module bubble_index_gen import bubble_pkg::*; #(
    parameter int N = IDX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] n_1,
    input  logic         step,
    input  logic         swapped_in,
    output logic         cmp_valid,
    output logic [N-1:0] idx_j,
    output logic [N-1:0] idx_i,
    output logic         busy,
    output logic         pass_done,
    output logic         done
);
    state_e       state_q, state_d;
    logic [N-1:0] lim_q, lim_d, i_q, i_d;
    logic         swap_q, swap_d, j_clr, j_en, j_last;
    bubble_j_counter #(.N(N)) u_j (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (j_clr),
        .en_i   (j_en),
        .lim_i  (lim_q),
        .i_i    (i_q),
        .j_o    (idx_j),
        .last_o (j_last)
    );
    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        i_d     = i_q;
        swap_d  = swap_q;
        j_clr   = 1'b0;
        j_en    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                lim_d   = n_1;
                i_d     = '0;
                swap_d  = 1'b0;
                j_clr   = 1'b1;
                state_d = n_1 != '0 ? CMP : DONE;
            end
            CMP: if (step) begin
                swap_d  = swap_q | swapped_in;
                j_en    = !j_last;
                state_d = j_last ? PASS_END : CMP;
            end
            PASS_END: if (!swap_q || i_q == lim_q - 1'b1) begin
                state_d = DONE;
            end else begin
                i_d     = i_q + 1'b1;
                swap_d  = 1'b0;
                j_clr   = 1'b1;
                state_d = CMP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            lim_q   <= '0;
            i_q     <= '0;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            i_q     <= i_d;
            swap_q  <= swap_d;
        end
    end
    assign cmp_valid = state_q == CMP;
    assign pass_done = state_q == PASS_END;
    assign done      = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign idx_i     = i_q;
endmodule
